// File: rtl/mod_accum_ctrl_if.sv
// Operand-in / result-out handshake bundle for the modular accumulate sequencer.
// Job control (start/len/mod) travels with the streams so one port carries a whole job.
interface mod_accum_ctrl_if #(
    parameter int BITWIDTH = 32,
    parameter int CNTWIDTH = 8
);
    logic                iStart;
    logic [CNTWIDTH-1:0] iLen;
    logic [BITWIDTH-1:0] iMod;
    logic                iValid;
    logic [BITWIDTH-1:0] iData;
    logic                oReady;
    logic                oValid;
    logic [BITWIDTH-1:0] oData;
    logic                iReady;
    logic                oBusy;

    modport slave (
        input  iStart, iLen, iMod, iValid, iData, iReady,
        output oReady, oValid, oData, oBusy
    );

    modport master (
        output iStart, iLen, iMod, iValid, iData, iReady,
        input  oReady, oValid, oData, oBusy
    );
endinterface

// File: rtl/mod_accum_ctrl.sv
// Reduces a stream of iLen operands to their sum mod iMod; result valid the cycle after the last beat.
// One operand per cycle in ACC; result held in DONE until the consumer raises iReady.
module mod_accum_ctrl #(
    parameter int BITWIDTH = 32,
    parameter int CNTWIDTH = 8
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    mod_accum_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);

    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] acc_q, acc_d;
    logic [BITWIDTH-1:0] mod_q, mod_d;
    logic [CNTWIDTH-1:0] cnt_q, cnt_d;
    logic [CNTWIDTH-1:0] len_q, len_d;

    logic                ready_w;
    logic                valid_w;
    logic [BITWIDTH-1:0] data_w;
    logic [BITWIDTH:0]   sum_w;
    logic [BITWIDTH:0]   diff_w;
    logic [BITWIDTH-1:0] modsum_w;

    // Sum kept one bit wider so a modulus near 2^BITWIDTH still sees the carry.
    assign sum_w    = {1'b0, acc_q} + {1'b0, bus.iData};
    assign diff_w   = sum_w - {1'b0, mod_q};
    assign modsum_w = (sum_w >= {1'b0, mod_q}) ? diff_w[BITWIDTH-1:0] : sum_w[BITWIDTH-1:0];

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mod_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mod_q   <= mod_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mod_d   = mod_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ready_w = 1'b0;
        valid_w = 1'b0;
        data_w  = '0;
        case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (bus.iLen != '0) begin
                        len_d   = bus.iLen;
                        mod_d   = bus.iMod;
                        state_d = ACC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACC: begin
                ready_w = 1'b1;
                if (bus.iValid) begin
                    acc_d = modsum_w;
                    cnt_d = cnt_q + CNT_ONE;
                    // len_q is never 0 here, so len_q-1 cannot wrap.
                    if (cnt_q == len_q - CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                valid_w = 1'b1;
                data_w  = acc_q;
                if (bus.iReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.oReady = ready_w;
    assign bus.oValid = valid_w;
    assign bus.oData  = data_w;
    assign bus.oBusy  = (state_q != IDLE);
endmodule

// File: tb/tb_mod_accum_ctrl.sv
// Bench for mod_accum_ctrl: table of directed jobs, hand-written corner sequences,
// then random jobs checked against a plain modulo-sum reference.
module tb_mod_accum_ctrl;
    logic iClk;
    logic iRstN;

    mod_accum_ctrl_if #(.BITWIDTH(32), .CNTWIDTH(8)) bus ();

    mod_accum_ctrl #(.BITWIDTH(32), .CNTWIDTH(8)) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .bus   (bus)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ops  [0:255];
    int          gaps [0:255];

    typedef struct {
        logic [31:0] m;
        int          len;
        logic [31:0] op [0:3];
        int          gap_at;
        int          gap_len;
        int          rdy_wait;
        bit          pulse_start;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [0:5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: fold operands with the % operator on 64-bit integers.
    function automatic logic [31:0] model(input logic [31:0] m, input int len);
        longint unsigned s;
        s = 0;
        for (int i = 0; i < len; i++) s = (s + longint'(ops[i])) % longint'(m);
        return s[31:0];
    endfunction

    task automatic set_vec(input int idx, input logic [31:0] m, input int len,
                           input logic [31:0] o0, input logic [31:0] o1,
                           input logic [31:0] o2, input logic [31:0] o3,
                           input int gap_at, input int gap_len, input int rdy_wait,
                           input bit pulse_start, input logic [31:0] exp);
        vecs[idx].m = m;             vecs[idx].len = len;
        vecs[idx].op[0] = o0;        vecs[idx].op[1] = o1;
        vecs[idx].op[2] = o2;        vecs[idx].op[3] = o3;
        vecs[idx].gap_at = gap_at;   vecs[idx].gap_len = gap_len;
        vecs[idx].rdy_wait = rdy_wait;
        vecs[idx].pulse_start = pulse_start;
        vecs[idx].exp = exp;
    endtask

    // Drives one job from ops[]/gaps[]; inputs change and outputs are sampled on the falling edge.
    task automatic run_job(input string nm, input logic [31:0] m, input int len,
                           input int rdy_wait, input bit pulse_start, input logic [31:0] exp);
        @(negedge iClk);
        bus.iStart = 1'b1;
        bus.iLen   = len[7:0];
        bus.iMod   = m;
        bus.iValid = 1'b1;
        bus.iData  = $urandom;
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                @(negedge iClk);
                bus.iStart = 1'b0;
                bus.iValid = 1'b0;
                bus.iData  = $urandom;
            end
            @(negedge iClk);
            check({nm, "_ready"}, {31'b0, bus.oReady}, 32'd1);
            bus.iStart = (i == 1);
            bus.iLen   = $urandom;
            bus.iMod   = $urandom;
            bus.iValid = 1'b1;
            bus.iData  = ops[i];
        end
        @(negedge iClk);
        bus.iStart = 1'b0;
        bus.iValid = 1'b1;
        bus.iData  = $urandom;
        check({nm, "_valid"}, {31'b0, bus.oValid}, 32'd1);
        check({nm, "_data"}, bus.oData, exp);
        check({nm, "_noready"}, {31'b0, bus.oReady}, 32'd0);
        for (int w = 0; w < rdy_wait; w++) begin
            @(negedge iClk);
            check({nm, "_hold_valid"}, {31'b0, bus.oValid}, 32'd1);
            check({nm, "_hold_data"}, bus.oData, exp);
            check({nm, "_hold_busy"}, {31'b0, bus.oBusy}, 32'd1);
            bus.iStart = pulse_start && (w == 1);
            bus.iLen   = 8'd3;
        end
        bus.iStart = 1'b0;
        bus.iValid = 1'b0;
        bus.iReady = 1'b1;
        @(negedge iClk);
        bus.iReady = 1'b0;
        check({nm, "_idle_busy"}, {31'b0, bus.oBusy}, 32'd0);
        check({nm, "_idle_valid"}, {31'b0, bus.oValid}, 32'd0);
    endtask

    initial begin
        bus.iStart = 1'b0;  bus.iLen = '0;    bus.iMod = '0;
        bus.iValid = 1'b0;  bus.iData = '0;   bus.iReady = 1'b0;
        iRstN = 1'b0;
        #1;
        check("rst_ready", {31'b0, bus.oReady}, 32'd0);
        check("rst_valid", {31'b0, bus.oValid}, 32'd0);
        check("rst_data",  bus.oData, 32'd0);
        check("rst_busy",  {31'b0, bus.oBusy}, 32'd0);
        #12 iRstN = 1'b1;

        set_vec(0, 32'd17, 4, 5, 9, 12, 16, 0, 0, 0, 1'b0, 32'd8);
        set_vec(1, 32'd17, 4, 5, 9, 12, 16, 2, 3, 0, 1'b0, 32'd8);
        set_vec(2, 32'd17, 4, 5, 9, 12, 16, 0, 0, 5, 1'b1, 32'd8);
        set_vec(3, 32'hFFFF_FFFB, 2, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 0, 0, 0, 0, 1, 1'b0, 32'hFFFF_FFF9);
        set_vec(4, 32'd17, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 32'd0);
        set_vec(5, 32'd1, 3, 0, 0, 0, 0, 1, 2, 2, 1'b0, 32'd0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                ops[i]  = vecs[v].op[i];
                gaps[i] = (i == vecs[v].gap_at) ? vecs[v].gap_len : 0;
            end
            run_job($sformatf("vec%0d", v), vecs[v].m, vecs[v].len,
                    vecs[v].rdy_wait, vecs[v].pulse_start, vecs[v].exp);
        end

        // Longest job: 255 ones under M=1000 must not wrap the count.
        for (int i = 0; i < 256; i++) begin ops[i] = 32'd1; gaps[i] = 0; end
        run_job("maxlen", 32'd1000, 255, 0, 1'b0, 32'd255);

        // Reset after two of four beats: outputs drop at once, no result appears.
        for (int i = 0; i < 4; i++) begin ops[i] = 32'd3; gaps[i] = 0; end
        @(negedge iClk);
        bus.iStart = 1'b1; bus.iLen = 8'd4; bus.iMod = 32'd17;
        @(negedge iClk);
        bus.iStart = 1'b0; bus.iValid = 1'b1; bus.iData = 32'd3;
        @(negedge iClk);
        @(negedge iClk);
        #1 iRstN = 1'b0;
        #1;
        check("midrst_ready", {31'b0, bus.oReady}, 32'd0);
        check("midrst_valid", {31'b0, bus.oValid}, 32'd0);
        check("midrst_data",  bus.oData, 32'd0);
        check("midrst_busy",  {31'b0, bus.oBusy}, 32'd0);
        bus.iValid = 1'b0;
        @(negedge iClk);
        iRstN = 1'b1;
        @(negedge iClk);
        check("postrst_busy",  {31'b0, bus.oBusy}, 32'd0);
        check("postrst_valid", {31'b0, bus.oValid}, 32'd0);
        ops[0] = 32'd3; ops[1] = 32'd4; ops[2] = 32'd6;
        run_job("postrst_job", 32'd7, 3, 0, 1'b0, 32'd6);

        for (int j = 0; j < 40; j++) begin
            logic [31:0] m;
            int          len;
            case ($urandom_range(0, 2))
                0:       m = $urandom_range(1, 60);
                1:       m = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: m = $urandom | 32'd1;
            endcase
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin
                ops[i]  = $urandom % m;
                gaps[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            run_job($sformatf("rand%0d", j), m, len, $urandom_range(0, 3),
                    $urandom_range(0, 1) == 1, model(m, len));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mod_accum_ctrl.md
Name: mod_accum_ctrl

Overview:
- Sequencer that drives one modular adder plus accumulator register to reduce a stream of iLen operands to their sum mod iMod.
- Sits between an operand source (valid/ready stream) and a result consumer (valid/ready).
- Serves as the building block for modular dot-product and NTT accumulate stages.
- Owns the start/length protocol, operand counting, accumulator clear/enable sequencing and result hand-off.

Parameters:
- BITWIDTH, 32, operand/modulus/result width.
- CNTWIDTH, 8, width of the length field; max job length 2^CNTWIDTH-1.

Ports:
- iClk  input  1  clock, rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iStart  input  1  single-cycle job start pulse; sampled only in IDLE.
- iLen  input  CNTWIDTH  number of operands in the job; sampled with iStart.
- iMod  input  BITWIDTH  modulus; sampled with iStart.
- iValid  input  1  operand valid.
- iData  input  BITWIDTH  operand; must be < latched modulus.
- oReady  output  1  controller accepts an operand this cycle.
- oValid  output  1  result valid.
- oData  output  BITWIDTH  result, the sum of the job's operands mod the latched modulus.
- iReady  input  1  consumer accepts the result.
- oBusy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (iRstN=0, asynchronous): state=IDLE; accumulator, count, latched length and latched modulus all 0. oReady=0, oValid=0, oData=0, oBusy=0.
- Reset asserted mid-job aborts the job immediately; no result is produced.
- States: IDLE, ACC, DONE.
- IDLE:
  - oReady=0, oValid=0.
  - iStart=1 and iLen!=0: latch iLen and iMod, clear accumulator to 0, count=0, go to ACC.
  - iStart=1 and iLen==0: clear accumulator, go to DONE (result 0).
  - iStart=0: remain in IDLE.
- ACC:
  - oReady=1.
  - Beat = iValid & oReady. On each beat: acc <= modadd(acc, iData), count <= count+1.
  - On the beat with count==len-1, go to DONE.
  - No beat: hold accumulator and count.
- DONE:
  - oValid=1, oReady=0, oData=accumulator.
  - oValid and oData stay stable until iReady=1; then go to IDLE on that edge.
- Latency: oValid rises the cycle after the last accepted beat. Back-to-back beats are accepted at one per cycle, so an N-operand job takes N cycles in ACC plus at least 1 cycle in DONE.
- modadd(a,b):
  - s = a + b computed in BITWIDTH+1 bits.
  - Result = s - M if s >= M, else s.
  - Valid only for a,b < M. Out-of-range operands give an unspecified result but no hang or state corruption.
- iStart while oBusy=1 is ignored; it is neither queued nor allowed to disturb the running job.
- iMod and iLen changes after the start cycle have no effect on the running job.
- iData is ignored whenever oReady=0.
- iStart is accepted in the cycle DONE returns to IDLE only on the following edge, so minimum turnaround is DONE to IDLE to ACC.
- Len = 2^CNTWIDTH-1: count must reach len-1 without overflow; no wrap.
- M = 1: every result is 0.
- M near 2^BITWIDTH-1: the carry bit of s must be honoured; no truncation before the compare.

Test Plan:
- Basic job: M=17, Len=4, operands 5,9,12,16 on back-to-back beats. Running sums 5, 14, 9, 8. oValid=1 one cycle after the 4th beat with oData=8; iReady=1 returns the controller to IDLE.
- Stalls: same job with iValid low for 3 cycles between beats 2 and 3. Accumulator and count hold during the gaps; result is still 8.
- Backpressure and ignored start: hold iReady=0 for 5 cycles in DONE. oValid and oData stay stable. A pulse of iStart during DONE is ignored, and oBusy stays 1 until iReady.
- Wide modulus carry: BITWIDTH=32, M=0xFFFFFFFB, Len=2, operands 0xFFFFFFFA and 0xFFFFFFFA. Expected result 0xFFFFFFF9, which exercises the 33-bit sum path.
- Zero length and max length:
  - Len=0 gives oValid the cycle after iStart with oData=0.
  - Len=255 (CNTWIDTH=8) with all operands 1 and M=1000 gives 255.
- Reset mid-job: drop iRstN after 2 of 4 beats. All outputs go to 0 immediately and state is IDLE. A new job (M=7, Len=3, operands 3,4,6) after reset completes with result 6.
